// File: rtl/writeback_stage_pkg.sv
// Shared types for the writeback stage: register index, data word,
// result-source selector and the registered commit record.
package writeback_stage_pkg;

    localparam int NUM_REGISTERS = 32;
    localparam int REG_IDX_W     = 5;
    localparam int DATA_W        = 32;

    typedef logic [REG_IDX_W-1:0] t_register_index;
    typedef logic [DATA_W-1:0]    t_data;

    typedef enum logic {
        WB_SRC_ALU  = 1'b0,
        WB_SRC_LOAD = 1'b1
    } t_wb_source;

    // Busy bit as seen by a consumer: a register committing this cycle is
    // already forwardable, and x0 is never busy.
    function automatic logic query_busy(
        input logic [NUM_REGISTERS-1:0] busy,
        input t_register_index          idx,
        input logic                     commit_en,
        input t_register_index          commit_idx
    );
        return busy[idx] && !(commit_en && (commit_idx == idx)) && (idx != '0);
    endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// Handshake and register-file bus of the writeback stage. The master side
// is the surrounding pipeline (issue, ALU, load unit, register file); the
// slave side is writeback_stage itself.
interface writeback_stage_if;
    import writeback_stage_pkg::*;

    // Issue reservation
    logic            i_issue_valid;
    t_register_index i_issue_rd;
    logic            o_issue_ready;

    // Hazard query
    t_register_index i_query_idx1;
    t_register_index i_query_idx2;
    logic            o_query_busy1;
    logic            o_query_busy2;

    // ALU result
    logic            i_alu_valid;
    t_register_index i_alu_rd;
    t_data           i_alu_data;
    logic            o_alu_ready;

    // Load result
    logic            i_load_valid;
    t_register_index i_load_rd;
    t_data           i_load_data;
    logic            o_load_ready;

    // Register file write port and forwarding bus
    logic            o_rf_write_enable;
    t_register_index o_rf_register_idx;
    t_data           o_rf_data;
    logic            o_fwd_valid;
    t_register_index o_fwd_idx;
    t_data           o_fwd_data;

    logic            o_unexpected;

    modport master (
        output i_issue_valid, i_issue_rd,
        input  o_issue_ready,
        output i_query_idx1, i_query_idx2,
        input  o_query_busy1, o_query_busy2,
        output i_alu_valid, i_alu_rd, i_alu_data,
        input  o_alu_ready,
        output i_load_valid, i_load_rd, i_load_data,
        input  o_load_ready,
        input  o_rf_write_enable, o_rf_register_idx, o_rf_data,
        input  o_fwd_valid, o_fwd_idx, o_fwd_data,
        input  o_unexpected
    );

    modport slave (
        input  i_issue_valid, i_issue_rd,
        output o_issue_ready,
        input  i_query_idx1, i_query_idx2,
        output o_query_busy1, o_query_busy2,
        input  i_alu_valid, i_alu_rd, i_alu_data,
        output o_alu_ready,
        input  i_load_valid, i_load_rd, i_load_data,
        output o_load_ready,
        output o_rf_write_enable, o_rf_register_idx, o_rf_data,
        output o_fwd_valid, o_fwd_idx, o_fwd_data,
        output o_unexpected
    );

endinterface

// File: rtl/writeback_stage_wb_arbiter.sv
// Two-way arbiter between the ALU and the load unit. Round-robin on
// contention when RR_ENABLE is set, otherwise the load unit always wins.
// Each ready depends only on the other source's valid.
module wb_arbiter
    import writeback_stage_pkg::*;
#(
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_alu_valid,
    input  logic       i_load_valid,
    output logic       o_alu_ready,
    output logic       o_load_ready,
    output logic       o_grant_valid,
    output t_wb_source o_grant
);

    // Source that wins the next contention cycle
    t_wb_source prio_src;
    logic       alu_wins_tie;
    logic       contention;

    // Tie-break decision and per-source readies
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every
        // path; here each is assigned unconditionally, so no latch can form.
        alu_wins_tie  = RR_ENABLE ? (prio_src == WB_SRC_ALU) : 1'b0;
        contention    = i_alu_valid && i_load_valid;
        o_alu_ready   = !i_load_valid || alu_wins_tie;
        o_load_ready  = !i_alu_valid  || !alu_wins_tie;
        o_grant_valid = (i_alu_valid && o_alu_ready) || (i_load_valid && o_load_ready);
        o_grant       = (i_load_valid && o_load_ready) ? WB_SRC_LOAD : WB_SRC_ALU;
    end

    // Round-robin pointer: moves only when both sources competed
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: state registers use non-blocking assignment so every flop
        // samples pre-edge values regardless of block ordering.
        if (!i_rst_n) begin
            prio_src <= WB_SRC_ALU;
        end else if (contention) begin
            prio_src <= alu_wins_tie ? WB_SRC_LOAD : WB_SRC_ALU;
        end
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: arbitrates ALU/load results onto the single register
// file write port with one cycle of latency, tracks pending writes per
// register for hazard detection, and mirrors the write as a forwarding bus.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter bit RR_ENABLE = 1'b1
) (
    input logic               i_clk,
    input logic               i_rst_n,
    writeback_stage_if.slave  wb
);

    logic                     alu_ready;
    logic                     load_ready;
    logic                     grant_valid;
    t_wb_source               grant;

    t_register_index          acc_rd;
    t_data                    acc_data;
    logic                     acc_write;
    logic                     issue_ready;
    logic                     issue_fire;

    logic [NUM_REGISTERS-1:0] busy;
    logic [NUM_REGISTERS-1:0] busy_next;
    logic                     rf_we;
    t_register_index          rf_idx;
    t_data                    rf_data;
    logic                     unexpected;

    wb_arbiter #(
        .RR_ENABLE (RR_ENABLE)
    ) u_arbiter (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_alu_valid   (wb.i_alu_valid),
        .i_load_valid  (wb.i_load_valid),
        .o_alu_ready   (alu_ready),
        .o_load_ready  (load_ready),
        .o_grant_valid (grant_valid),
        .o_grant       (grant)
    );

    // Select the accepted result and decide whether it produces a write
    always_comb begin
        acc_rd      = (grant == WB_SRC_LOAD) ? wb.i_load_rd   : wb.i_alu_rd;
        acc_data    = (grant == WB_SRC_LOAD) ? wb.i_load_data : wb.i_alu_data;
        acc_write   = grant_valid && (acc_rd != '0);
        issue_ready = !busy[wb.i_issue_rd] || (wb.i_issue_rd == '0);
        issue_fire  = wb.i_issue_valid && issue_ready && (wb.i_issue_rd != '0);
    end

    // Scoreboard update: commit clears, issue sets; set is applied last so it wins
    always_comb begin
        busy_next = busy;
        if (rf_we) begin
            busy_next[rf_idx] = 1'b0;
        end
        if (issue_fire) begin
            busy_next[wb.i_issue_rd] = 1'b1;
        end
    end

    // Pending-write scoreboard
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: the busy vector is reset even though it looks like storage:
        // a stale bit after reset would stall issue forever.
        if (!i_rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Commit register: one accepted result per cycle, x0 writes dropped
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rf_we   <= 1'b0;
            rf_idx  <= '0;
            rf_data <= '0;
        end else begin
            rf_we <= acc_write;
            if (acc_write) begin
                rf_idx  <= acc_rd;
                rf_data <= acc_data;
            end
        end
    end

    // Sticky flag for a result whose destination was never reserved
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            unexpected <= 1'b0;
        end else if (acc_write && !busy[acc_rd]) begin
            unexpected <= 1'b1;
        end
    end

    assign wb.o_issue_ready     = issue_ready;
    assign wb.o_alu_ready       = alu_ready;
    assign wb.o_load_ready      = load_ready;
    assign wb.o_query_busy1     = query_busy(busy, wb.i_query_idx1, rf_we, rf_idx);
    assign wb.o_query_busy2     = query_busy(busy, wb.i_query_idx2, rf_we, rf_idx);
    assign wb.o_rf_write_enable = rf_we;
    assign wb.o_rf_register_idx = rf_idx;
    assign wb.o_rf_data         = rf_data;
    assign wb.o_fwd_valid       = rf_we;
    assign wb.o_fwd_idx         = rf_idx;
    assign wb.o_fwd_data        = rf_data;
    assign wb.o_unexpected      = unexpected;

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: a round-robin instance carries the directed
// sequence, a fixed-priority instance shares reset for the arbitration case.
// Expected writes go into per-instance queues; negedge monitors pop and
// compare whenever a register file write is presented.
module tb_writeback_stage;
    import writeback_stage_pkg::*;

    typedef struct packed {
        t_register_index rd;
        t_data           data;
    } exp_t;

    logic i_clk;
    logic i_rst_n;

    writeback_stage_if wb_rr ();
    writeback_stage_if wb_fp ();

    writeback_stage #(.RR_ENABLE(1'b1)) dut_rr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .wb      (wb_rr.slave)
    );

    writeback_stage #(.RR_ENABLE(1'b0)) dut_fp (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .wb      (wb_fp.slave)
    );

    exp_t q_rr[$];
    exp_t q_fp[$];
    int   n_vec = 0;
    int   n_bad = 0;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Monitor for the round-robin instance
    always @(negedge i_clk) begin
        if (i_rst_n && wb_rr.o_rf_write_enable === 1'b1) begin
            if (q_rr.size() == 0) begin
                check("rr_write_without_expectation", 32'(q_rr.size()), 32'd1);
            end else begin
                exp_t e;
                e = q_rr.pop_front();
                check("rr_rf_idx",    32'(wb_rr.o_rf_register_idx), 32'(e.rd));
                check("rr_rf_data",   wb_rr.o_rf_data, e.data);
                check("rr_fwd_valid", 32'(wb_rr.o_fwd_valid), 32'd1);
                check("rr_fwd_idx",   32'(wb_rr.o_fwd_idx), 32'(e.rd));
                check("rr_fwd_data",  wb_rr.o_fwd_data, e.data);
            end
        end
    end

    // Monitor for the fixed-priority instance
    always @(negedge i_clk) begin
        if (i_rst_n && wb_fp.o_rf_write_enable === 1'b1) begin
            if (q_fp.size() == 0) begin
                check("fp_write_without_expectation", 32'(q_fp.size()), 32'd1);
            end else begin
                exp_t e;
                e = q_fp.pop_front();
                check("fp_rf_idx",  32'(wb_fp.o_rf_register_idx), 32'(e.rd));
                check("fp_rf_data", wb_fp.o_rf_data, e.data);
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
        $fatal(1, "timeout");
    end

    initial begin
        wb_rr.i_issue_valid = 0; wb_rr.i_issue_rd = 0;
        wb_rr.i_query_idx1  = 0; wb_rr.i_query_idx2 = 0;
        wb_rr.i_alu_valid   = 0; wb_rr.i_alu_rd  = 0; wb_rr.i_alu_data  = 0;
        wb_rr.i_load_valid  = 0; wb_rr.i_load_rd = 0; wb_rr.i_load_data = 0;
        wb_fp.i_issue_valid = 0; wb_fp.i_issue_rd = 0;
        wb_fp.i_query_idx1  = 0; wb_fp.i_query_idx2 = 0;
        wb_fp.i_alu_valid   = 0; wb_fp.i_alu_rd  = 0; wb_fp.i_alu_data  = 0;
        wb_fp.i_load_valid  = 0; wb_fp.i_load_rd = 0; wb_fp.i_load_data = 0;

        // Reset state
        i_rst_n = 1'b1;
        #2 i_rst_n = 1'b0;
        #1;
        check("reset_we",         32'(wb_rr.o_rf_write_enable), 32'd0);
        check("reset_idx",        32'(wb_rr.o_rf_register_idx), 32'd0);
        check("reset_data",       wb_rr.o_rf_data, 32'd0);
        check("reset_unexpected", 32'(wb_rr.o_unexpected), 32'd0);
        tick();
        tick();
        i_rst_n = 1'b1;
        tick();
        check("idle_alu_ready",    32'(wb_rr.o_alu_ready), 32'd1);
        check("idle_load_ready",   32'(wb_rr.o_load_ready), 32'd1);
        check("fp_idle_alu_ready", 32'(wb_fp.o_alu_ready), 32'd1);

        // Basic issue and ALU commit to x5
        wb_rr.i_issue_valid = 1; wb_rr.i_issue_rd = 5; wb_rr.i_query_idx1 = 5;
        #1 check("t1_issue_ready", 32'(wb_rr.o_issue_ready), 32'd1);
        tick();
        wb_rr.i_issue_valid = 0;
        wb_rr.i_alu_valid = 1; wb_rr.i_alu_rd = 5; wb_rr.i_alu_data = 32'hDEAD_BEEF;
        q_rr.push_back('{rd: 5'd5, data: 32'hDEAD_BEEF});
        #1;
        check("t1_alu_ready",   32'(wb_rr.o_alu_ready), 32'd1);
        check("t1_busy_before", 32'(wb_rr.o_query_busy1), 32'd1);
        tick();
        wb_rr.i_alu_valid = 0;
        #1 check("t1_busy_commit", 32'(wb_rr.o_query_busy1), 32'd0);
        tick();
        #1;
        check("t1_busy_after",  32'(wb_rr.o_query_busy1), 32'd0);
        check("t1_we_after",    32'(wb_rr.o_rf_write_enable), 32'd0);
        check("t1_unexpected",  32'(wb_rr.o_unexpected), 32'd0);

        // WAW blocking on x3 and query around its commit
        wb_rr.i_issue_valid = 1; wb_rr.i_issue_rd = 3;
        wb_rr.i_query_idx1 = 3; wb_rr.i_query_idx2 = 3;
        #1 check("t2_first_issue_ready", 32'(wb_rr.o_issue_ready), 32'd1);
        tick();
        wb_rr.i_alu_valid = 1; wb_rr.i_alu_rd = 3; wb_rr.i_alu_data = 32'h0000_0033;
        q_rr.push_back('{rd: 5'd3, data: 32'h0000_0033});
        #1;
        check("t2_second_issue_blocked", 32'(wb_rr.o_issue_ready), 32'd0);
        check("t2_busy1_before", 32'(wb_rr.o_query_busy1), 32'd1);
        check("t2_busy2_before", 32'(wb_rr.o_query_busy2), 32'd1);
        tick();
        wb_rr.i_alu_valid = 0;
        #1;
        check("t2_issue_blocked_commit", 32'(wb_rr.o_issue_ready), 32'd0);
        check("t2_busy1_commit", 32'(wb_rr.o_query_busy1), 32'd0);
        check("t2_fwd_data",     wb_rr.o_fwd_data, 32'h0000_0033);
        tick();
        #1 check("t2_issue_ready_after", 32'(wb_rr.o_issue_ready), 32'd1);
        tick();
        wb_rr.i_issue_valid = 0;
        #1 check("t2_rebusy", 32'(wb_rr.o_query_busy2), 32'd1);
        wb_rr.i_alu_valid = 1; wb_rr.i_alu_rd = 3; wb_rr.i_alu_data = 32'h0000_0333;
        q_rr.push_back('{rd: 5'd3, data: 32'h0000_0333});
        tick();
        wb_rr.i_alu_valid = 0;
        tick();
        #1 check("t2_busy_cleared", 32'(wb_rr.o_query_busy1), 32'd0);

        // x0 result is accepted and dropped
        wb_rr.i_query_idx2 = 0;
        wb_rr.i_load_valid = 1; wb_rr.i_load_rd = 0; wb_rr.i_load_data = 32'hFFFF_FFFF;
        #1 check("t4_load_ready", 32'(wb_rr.o_load_ready), 32'd1);
        tick();
        wb_rr.i_load_valid = 0;
        #1;
        check("t4_no_write",    32'(wb_rr.o_rf_write_enable), 32'd0);
        check("t4_idx_held",    32'(wb_rr.o_rf_register_idx), 32'd3);
        check("t4_x0_busy",     32'(wb_rr.o_query_busy2), 32'd0);
        check("t4_unexpected",  32'(wb_rr.o_unexpected), 32'd0);
        tick();

        // Result for an unreserved register: write proceeds, flag sticks
        wb_rr.i_alu_valid = 1; wb_rr.i_alu_rd = 7; wb_rr.i_alu_data = 32'h0000_0077;
        q_rr.push_back('{rd: 5'd7, data: 32'h0000_0077});
        #1 check("t5_unexpected_before", 32'(wb_rr.o_unexpected), 32'd0);
        tick();
        wb_rr.i_alu_valid = 0;
        #1 check("t5_unexpected_set", 32'(wb_rr.o_unexpected), 32'd1);
        tick(); tick(); tick();
        check("t5_unexpected_sticky", 32'(wb_rr.o_unexpected), 32'd1);

        // Contention: RR alternates starting with ALU, fixed priority picks load
        wb_rr.i_alu_valid  = 1; wb_rr.i_alu_rd  = 1; wb_rr.i_alu_data  = 32'h11;
        wb_rr.i_load_valid = 1; wb_rr.i_load_rd = 2; wb_rr.i_load_data = 32'h22;
        wb_fp.i_alu_valid  = 1; wb_fp.i_alu_rd  = 1; wb_fp.i_alu_data  = 32'h11;
        wb_fp.i_load_valid = 1; wb_fp.i_load_rd = 2; wb_fp.i_load_data = 32'h22;
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("t3_rr_alu_ready_c%0d", c),  32'(wb_rr.o_alu_ready),  (c % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("t3_rr_load_ready_c%0d", c), 32'(wb_rr.o_load_ready), (c % 2 == 1) ? 32'd1 : 32'd0);
            check($sformatf("t3_fp_alu_ready_c%0d", c),  32'(wb_fp.o_alu_ready),  32'd0);
            check($sformatf("t3_fp_load_ready_c%0d", c), 32'(wb_fp.o_load_ready), 32'd1);
            if (c % 2 == 0) q_rr.push_back('{rd: 5'd1, data: 32'h11});
            else            q_rr.push_back('{rd: 5'd2, data: 32'h22});
            q_fp.push_back('{rd: 5'd2, data: 32'h22});
            tick();
        end
        wb_rr.i_alu_valid = 0; wb_rr.i_load_valid = 0;
        wb_fp.i_alu_valid = 0; wb_fp.i_load_valid = 0;
        tick();
        tick();

        // Reset while a write to x9 is in the commit register
        wb_rr.i_issue_valid = 1; wb_rr.i_issue_rd = 9; wb_rr.i_query_idx1 = 9;
        tick();
        wb_rr.i_issue_valid = 0;
        wb_rr.i_alu_valid = 1; wb_rr.i_alu_rd = 9; wb_rr.i_alu_data = 32'h0000_0099;
        #1;
        check("t6_alu_ready",      32'(wb_rr.o_alu_ready), 32'd1);
        check("t6_unexpected_hi",  32'(wb_rr.o_unexpected), 32'd1);
        tick();
        wb_rr.i_alu_valid = 0;
        i_rst_n = 1'b0;
        #1;
        check("t6_we_in_reset",         32'(wb_rr.o_rf_write_enable), 32'd0);
        check("t6_idx_in_reset",        32'(wb_rr.o_rf_register_idx), 32'd0);
        check("t6_data_in_reset",       wb_rr.o_rf_data, 32'd0);
        check("t6_busy9_in_reset",      32'(wb_rr.o_query_busy1), 32'd0);
        check("t6_unexpected_in_reset", 32'(wb_rr.o_unexpected), 32'd0);
        tick();
        tick();
        i_rst_n = 1'b1;
        tick(); tick(); tick();
        check("t6_busy9_after",     32'(wb_rr.o_query_busy1), 32'd0);
        check("t6_issue9_ready",    32'(wb_rr.o_issue_ready), 32'd1);
        check("t6_we_after",        32'(wb_rr.o_rf_write_enable), 32'd0);
        check("t6_unexpected_low",  32'(wb_rr.o_unexpected), 32'd0);

        // Every expected write must have been observed
        check("rr_queue_drained", 32'(q_rr.size()), 32'd0);
        check("fp_queue_drained", 32'(q_fp.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Single-write-port writeback stage that sits directly upstream of the general-purpose register file and drives its write index, data and enable.
- Arbitrates between two result producers, the ALU and the load unit, over valid/ready handshakes.
- Keeps a per-register pending-write scoreboard so issue logic can detect RAW/WAW hazards.
- Exposes the committing write as a forwarding bus, because register-file reads are asynchronous and return the old value during the write cycle.

Parameters:
RR_ENABLE, 1, 1 = round-robin arbitration between ALU and load; 0 = fixed priority, load wins.

Ports:
i_clk  in  1  clock; all state updates on rising edge
i_rst_n  in  1  reset, asynchronous, active-low
i_issue_valid  in  1  issue logic requests to reserve i_issue_rd
i_issue_rd  in  t_register_index  destination of instruction being issued
o_issue_ready  out  1  reservation accepted this cycle
i_query_idx1  in  t_register_index  source register 1 to check
i_query_idx2  in  t_register_index  source register 2 to check
o_query_busy1  out  1  idx1 has an outstanding write not yet forwardable
o_query_busy2  out  1  same for idx2
i_alu_valid  in  1  ALU result present
i_alu_rd  in  t_register_index  ALU destination
i_alu_data  in  t_data  ALU result
o_alu_ready  out  1  ALU result accepted this cycle
i_load_valid, i_load_rd, i_load_data, o_load_ready  same as ALU group, for the load unit
o_rf_write_enable  out  1  drives register file write enable
o_rf_register_idx  out  t_register_index  drives register file write index
o_rf_data  out  t_data  drives register file write data
o_fwd_valid  out  1  equals o_rf_write_enable
o_fwd_idx  out  t_register_index  equals o_rf_register_idx
o_fwd_data  out  t_data  equals o_rf_data
o_unexpected  out  1  sticky: a result arrived for a register that was not busy

Behaviour:
- Reset (async, i_rst_n low):
  - all 32 busy bits = 0; o_rf_write_enable = 0; o_rf_register_idx = 0; o_rf_data = 0; o_unexpected = 0.
  - The round-robin pointer is set so the ALU wins the first tie.
  - A reset mid-operation discards in-flight results and reservations, with no partial write.
- Issue:
  - o_issue_ready = !busy[i_issue_rd] || i_issue_rd == 0. This is combinational and blocks WAW.
  - On handshake with rd != 0, busy[rd] is set at the next edge.
  - rd = 0 never sets busy.
- Arbitration (combinational):
  - Only one valid: that source gets ready = 1.
  - Both valid with RR_ENABLE = 1: grant goes to the source not granted in the last contention. The pointer updates only on contention cycles.
  - Both valid with RR_ENABLE = 0: load is granted.
  - Neither valid: both readies = 1.
  - Ready never depends on valid from the same source.
- Commit, 1-cycle latency:
  - The accepted result is registered. Next cycle o_rf_write_enable = 1 only if rd != 0, with idx and data from the accepted result.
  - rd = 0 results are accepted and dropped: enable stays 0.
  - Non-accept cycle: enable = 0; idx and data hold their last values.
- Scoreboard clear:
  - busy[idx] clears at the edge ending a cycle where o_rf_write_enable = 1.
  - Set and clear on the same index in the same edge cannot occur, because issue requires the register to be not busy. If it is ever forced, set wins.
- Query:
  - o_query_busyN = busy[idxN] && !(o_rf_write_enable && o_rf_register_idx == idxN) && idxN != 0.
  - A register committing this cycle is reported not busy; the consumer takes o_fwd_data.
- Unexpected result:
  - Accepting a result with rd != 0 and busy[rd] = 0 sets o_unexpected until reset.
  - The write still proceeds.
- Throughput: one write per cycle sustained; the losing source waits and must hold its valid, rd and data.

Decomposition:
- Package (definitions): t_register_index (5 bits), t_data (32 bits), NUM_REGISTERS = 32, t_wb_source enum {WB_SRC_ALU, WB_SRC_LOAD}.
- One sub-module, wb_arbiter: 2-way round-robin/fixed-priority arbiter with its pointer register.
- Scoreboard and commit register stay in writeback_stage.

Test Plan:
- Reset, issue rd = 5, ALU result rd = 5, data 0xDEADBEEF -> next cycle enable = 1, idx = 5, data 0xDEADBEEF; busy[5] = 0 afterwards; o_unexpected = 0.
- Issue rd = 3, then issue rd = 3 again -> second o_issue_ready = 0 until rd = 3 commits; query idx1 = 3 reads busy = 1 before commit and 0 during the commit cycle with o_fwd_data valid.
- ALU (rd = 1, 0x11) and load (rd = 2, 0x22) valid together for 4 cycles, RR_ENABLE = 1 -> grants alternate ALU, load, ALU, load. With RR_ENABLE = 0 -> load is always granted and ALU ready = 0.
- Result with rd = 0, data 0xFFFFFFFF -> accepted, enable stays 0, no busy change, o_unexpected = 0.
- ALU result rd = 7 with busy[7] = 0 -> write occurs and o_unexpected goes high and stays high until reset.
- Issue rd = 9, ALU result accepted, assert i_rst_n = 0 before the commit edge -> enable = 0 immediately, busy[9] = 0, and no write after reset release.
